seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised multi-cycle integer divider; successor to the single-cycle DIV path feeding ZHI/ZLO.
- Radix-2 restoring algorithm with signed/unsigned mode, start/done handshake and divide-by-zero detection.
- Produces quotient (destined for LO) and remainder (destined for HI).
- Sits beside the ALU; the control unit stalls on busy and loads LO/HI on done.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- quotient  output  WIDTH  result quotient (LO).
- remainder  output  WIDTH  result remainder (HI).
- div_by_zero  output  1  set with done when divisor was zero; held until next accepted start.

Behaviour:
- Reset (clr low, async): state=IDLE, counter=0. Outputs busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Aborts any in-flight operation; no done is produced for it.
- States:
  - IDLE: rising edge with start=1 accepts. Latches |dividend| and |divisor|; |x| = x in unsigned mode, two's-complement negation if x negative in signed mode. Latches sign flags (q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend), signed mode only). Clears partial remainder; counter=WIDTH; busy=1; div_by_zero cleared. Next state is ITER, or DZ if divisor==0.
  - ITER: each edge shifts the {remainder, quotient} pair left 1 and trial-subtracts the divisor. Restores if negative; quotient LSB = 1 if no restore. Counter decrements; after WIDTH iterations goes to FIX.
  - FIX: one edge. quotient = q_neg ? -q : q; remainder = r_neg ? -r : r. done=1 for exactly this following cycle; busy=0; back to IDLE.
  - DZ: one edge. quotient = all ones, remainder = original dividend (unmodified, sign included), div_by_zero=1, done=1, busy=0, back to IDLE.
- Latency:
  - Normal op: accept on edge k; done high after edge k+WIDTH+1 (WIDTH+1 cycles).
  - Divide-by-zero: done high after edge k+1.
  - done pulse and busy deassertion occur on the same edge.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend. Most-negative / -1 yields quotient = most-negative (wraps), remainder=0, no flag.
- Operand widths: internal partial remainder is WIDTH+1 bits so trial subtraction cannot lose the borrow. Abs of most-negative is treated as unsigned 2^(WIDTH-1).
- Handshake:
  - start while busy is ignored; inputs are not re-sampled.
  - start in the same cycle done is high is accepted (back-to-back operation) since the state is IDLE.
  - quotient, remainder and div_by_zero hold their last values until the next FIX/DZ or reset; they do not change during ITER.

Test Plan:
- Unsigned, WIDTH=32: dividend=0x00000062, divisor=0x00000007, signed_mode=0 -> done 33 cycles after accept; quotient=0x0000000E, remainder=0x00000000, div_by_zero=0.
- Signed: dividend=0xFFFFFF9C (-100), divisor=0x00000007 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100 / 0xFFFFFFF9 (-7) -> quotient=0xFFFFFFF2, remainder=0x00000002.
- Unsigned large: 0xFFFFFFFF / 0x00000010 -> quotient=0x0FFFFFFF, remainder=0x0000000F. The same operands in signed mode -> quotient=0, remainder=0xFFFFFFFF.
- Divide by zero: dividend=0x00000F0F, divisor=0 -> done 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x00000F0F, div_by_zero=1. The next valid op clears the flag.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, div_by_zero=0.
- Control:
  - start pulsed at cycle 5 of an op -> ignored, original result correct.
  - clr low at cycle 10 of an op -> busy=0 immediately, outputs 0, no done.
  - start held high through done -> second op accepted back-to-back.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring integer divider, signed or unsigned.
// One quotient bit per cycle. The quotient feeds LO and the remainder
// feeds HI. busy stalls the control unit, and done tells it to load
// the results.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DZ
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;

    // The working remainder is one bit wider than the operands so the trial
    // subtraction keeps its borrow. quo_w shifts in quotient bits as the
    // dividend bits shift out. In the divide-by-zero case, quo_w holds the
    // raw dividend.
    logic [WIDTH:0]   rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             dvs_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             restore;

    // Operand magnitudes. Negating the most-negative value wraps to itself,
    // and that result reads correctly as the unsigned value 2^(WIDTH-1).
    assign dvd_neg  = signed_mode & dividend[WIDTH-1];
    assign dvs_neg  = signed_mode & divisor[WIDTH-1];
    assign dvd_abs  = dvd_neg ? -dividend : dividend;
    assign dvs_abs  = dvs_neg ? -divisor : divisor;
    assign dvs_zero = (divisor == '0);

    // One restoring step: shift in the next dividend bit, then try to
    // subtract. A set top bit of trial means the result went negative,
    // so the shifted value is kept.
    assign shifted  = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvsr};
    assign restore  = trial[WIDTH+1];

    assign busy     = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default comes first so no path leaves state_nx unassigned,
        // which would otherwise infer a latch.
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = dvs_zero ? S_DZ : S_ITER;
            S_ITER: if (cnt == CNT_W'(1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_IDLE;
            S_DZ:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, then apply signs and publish.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt         <= '0;
            rem_w       <= '0;
            quo_w       <= '0;
            dvsr        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= CNT_W'(WIDTH);
                        rem_w       <= '0;
                        quo_w       <= dvs_zero ? dividend : dvd_abs;
                        dvsr        <= dvs_abs;
                        q_neg       <= dvd_neg ^ dvs_neg;
                        r_neg       <= dvd_neg;
                        div_by_zero <= 1'b0;
                    end
                end
                S_ITER: begin
                    rem_w <= restore ? shifted : trial[WIDTH:0];
                    quo_w <= {quo_w[WIDTH-2:0], ~restore};
                    cnt   <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    quotient  <= q_neg ? -quo_w : quo_w;
                    remainder <= r_neg ? -rem_w[WIDTH-1:0] : rem_w[WIDTH-1:0];
                    done      <= 1'b1;
                end
                S_DZ: begin
                    quotient    <= '1;
                    remainder   <= quo_w;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboard-checked bench for seq_divider
// with WIDTH=32. It also runs hand-written sequences for ignored start,
// abort by reset and back-to-back issue.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk;
    logic         clr;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model built on the language's own signed/unsigned operators.
    function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.lat = LAT;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0;
        end else if (sm) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Present one request for one edge and queue its expectation.
    task automatic drive_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        signed_mode = sm; dividend = a; divisor = b; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("dz_cleared_on_accept", div_by_zero, 0);
    endtask

    // Count edges from accept until done, optionally pulsing a spurious start.
    task automatic wait_done(input int poke, output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (poke >= 0) begin
                start = (lat == poke);
                if (lat == poke) begin
                    dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003; signed_mode = 1'b1;
                end
            end
        end
        check("done_seen", done, 1);
    endtask

    task automatic compare(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_quotient"}, quotient, e.q);
        check({tag, "_remainder"}, remainder, e.r);
        check({tag, "_div_by_zero"}, div_by_zero, e.dz);
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        int   lat;
        int   done_cnt;
        exp_t e;
        logic sm;
        logic [W-1:0] a, b;

        vecs[0] = '{1'b0, 32'h0000_0062, 32'h0000_0007, 32'h0000_000E, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0F0F, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0F0F, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0064, 32'h0000_0005, 32'h0000_0014, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{1'b1, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0000_0000, 32'h0000_0005, 1'b0};

        clr = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_by_zero", div_by_zero, 0);
        clr = 1'b1;

        // Directed vectors from the table.
        for (int i = 0; i < 10; i++) begin
            e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
            e.lat = vecs[i].dz ? 1 : LAT;
            drive_op(vecs[i].sm, vecs[i].a, vecs[i].b, e);
            wait_done(-1, lat);
            compare($sformatf("vec%0d", i), lat);
        end

        // Randomised operands checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            sm = i[0];
            a  = $urandom;
            b  = (i < 3) ? W'($urandom_range(1, 1000)) : W'($urandom);
            if (b == 0) b = 32'h0000_0001;
            if (sm && i[1]) b = -b;
            drive_op(sm, a, b, model(sm, a, b));
            wait_done(-1, lat);
            compare($sformatf("rnd%0d", i), lat);
        end

        // Start pulsed mid-operation with different operands is ignored.
        drive_op(1'b0, 32'h0001_0000, 32'h0000_0003, model(1'b0, 32'h0001_0000, 32'h0000_0003));
        wait_done(5, lat);
        start = 1'b0;
        compare("ignored_start", lat);

        // Start held high through done: a second operation issues back-to-back.
        // The operands change while busy, which also shows that they are not
        // re-sampled during the first operation.
        @(negedge clk);
        signed_mode = 1'b0; dividend = 32'h0000_03E8; divisor = 32'h0000_0007; start = 1'b1;
        sb.push_back(model(1'b0, 32'h0000_03E8, 32'h0000_0007));
        @(negedge clk);
        dividend = 32'hFFFF_FFF0; divisor = 32'h0000_0003; signed_mode = 1'b1;
        wait_done(-1, lat);
        compare("b2b_first", lat);
        sb.push_back(model(1'b1, 32'hFFFF_FFF0, 32'h0000_0003));
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_done(-1, lat);
        compare("b2b_second", lat);

        // Reset asserted mid-operation aborts it with no done.
        drive_op(1'b0, 32'h1234_5678, 32'h0000_0123, model(1'b0, 32'h1234_5678, 32'h0000_0123));
        repeat (9) @(negedge clk);
        clr = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 0);
        void'(sb.pop_front());
        @(negedge clk);
        clr = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);

        // Normal operation resumes after the abort.
        drive_op(1'b1, 32'hFFFF_FC18, 32'h0000_000B, model(1'b1, 32'hFFFF_FC18, 32'h0000_000B));
        wait_done(-1, lat);
        compare("post_abort", lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
